// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between the
// instruction-fetch path and the load/store path of the MIPS core.
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ready,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ready,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t     state;
    state_t     next_state;
    logic       owner;
    logic       last_owner;
    logic [2:0] cnt;
    logic       any_req;
    logic       grant_data;

    // owner/last_owner encoding: 1 = data path, 0 = fetch path
    always_comb begin
        any_req    = if_req || d_req;
        grant_data = d_req && (!if_req || !last_owner);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (any_req) next_state = ACCESS;
            ACCESS:  next_state = WAIT;
            WAIT:    if (cnt == 3'd1) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Grant registers, latency counter and per-requester read-data capture
    always_ff @(posedge clk) begin
        if (!reset) begin
            owner      <= 1'b0;
            last_owner <= 1'b0;
            cnt        <= 3'd0;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner    <= grant_data;
                        mem_addr <= grant_data ? d_addr : if_addr;
                        mem_we   <= grant_data && d_we;
                        if (grant_data) begin
                            mem_wdata <= d_wdata;
                        end
                    end
                end
                ACCESS: begin
                    cnt <= 3'(MEM_LAT);
                end
                WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1 && !mem_we) begin
                        if (owner) begin
                            d_rdata <= mem_rdata;
                        end else begin
                            if_rdata <= mem_rdata;
                        end
                    end
                end
                RESP: begin
                    last_owner <= owner;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        mem_en   = (state == ACCESS);
        busy     = (state != IDLE);
        if_ready = (state == RESP) && !owner;
        d_ready  = (state == RESP) && owner;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter for the MIPS core. It shares one unified instruction/data memory between the instruction-fetch path (PC/instruction-memory side) and the load/store path (ALU address, register-bank write data). Arbitration is round-robin, with a fixed-latency memory handshake. Each requester sees a hold-request / one-cycle-ready protocol.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width
- `MEM_LAT`, 2, cycles from `mem_en` to valid `mem_rdata`; legal range 1..7

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-low reset (0 = reset)
- `if_req`  in  1  fetch request; held high until `if_ready`
- `if_addr`  in  AW  fetch address; stable while `if_req`=1
- `if_ready`  out  1  one-cycle pulse; `if_rdata` valid in the same cycle
- `if_rdata`  out  DW  fetched word (registered)
- `d_req`  in  1  data request; held high until `d_ready`
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  AW  data address
- `d_wdata`  in  DW  store data
- `d_ready`  out  1  one-cycle completion pulse for load or store
- `d_rdata`  out  DW  load data (registered)
- `mem_en`  out  1  one-cycle memory strobe
- `mem_we`  out  1  write enable; qualified by `mem_en`
- `mem_addr`  out  AW  memory address
- `mem_wdata`  out  DW  memory write data
- `mem_rdata`  in  DW  memory read data; valid exactly `MEM_LAT` cycles after `mem_en`
- `busy`  out  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, ACCESS, WAIT, RESP.
- **IDLE**
  - Request inputs are sampled only in IDLE.
  - No request: stay in IDLE.
  - Exactly one request: grant it.
  - Both requests: grant the requester that was not the last owner.
  - On grant: register owner, `mem_addr`, `mem_we` (= `d_we` for data, 0 for fetch) and `mem_wdata` (= `d_wdata` for data, unchanged for fetch). Go to ACCESS.
- **ACCESS**
  - `mem_en`=1 for this cycle only.
  - Load the 3-bit latency counter with `MEM_LAT`. Go to WAIT.
- **WAIT**
  - Decrement the counter each cycle.
  - In the cycle the counter reaches 1, capture `mem_rdata` into the owner's rdata register, only if this is a read. Go to RESP.
  - Stores leave `d_rdata` unchanged.
- **RESP**
  - Pulse the owner's ready for one cycle.
  - Update last-owner to the current owner. Go to IDLE.
  - Requests are ignored in this cycle; requesters are still holding `req` high here.
- `mem_addr`, `mem_we` and `mem_wdata` hold their values from grant until the next grant. `mem_we` is meaningful only while `mem_en`=1.
- Address bits pass through unmodified. No alignment checking.
- A requester that drops `req` before its ready pulse violates the protocol. The arbiter still completes the transaction and pulses ready.

## Timing
- Request sampled in IDLE at cycle t produces:
  - `mem_en` high in cycle t+1.
  - `mem_rdata` sampled at the end of cycle t+1+`MEM_LAT`.
  - ready (and its rdata) visible in cycle t+2+`MEM_LAT`.
  - IDLE again in cycle t+3+`MEM_LAT`.
- Peak throughput is one access per `MEM_LAT`+3 cycles. With `MEM_LAT`=2: grant at 0, `mem_en` at 1, ready at 4, next grant possible at 5.
- Reset (`reset`=0 at a rising edge) produces, from the next cycle:
  - state = IDLE.
  - All outputs 0: `if_ready`, `d_ready`, `if_rdata`, `d_rdata`, `mem_en`, `mem_we`, `mem_addr`, `mem_wdata`, `busy`.
  - Last-owner = fetch, so data wins the first tie.
- Reset mid-transaction aborts it. No ready pulse is issued for the aborted access. `mem_en` is never re-issued for it.
- Counter never wraps: `MEM_LAT` ≥ 1 and the counter is loaded only in ACCESS.
- Ready outputs are never high simultaneously. At most one `mem_en` is outstanding.

## Test plan
- **Single fetch** (`MEM_LAT`=2, memory returns `0x8C220004` at address `0x40`): `if_req` at cycle 0 → `mem_en`=1, `mem_addr`=`0x40`, `mem_we`=0 at cycle 1; `if_ready`=1 with `if_rdata`=`0x8C220004` at cycle 4 only; `busy` high for cycles 1–4.
- **Store then load** (same address `0x100`, data `0xDEADBEEF`): `mem_we`=1 with `mem_en`; `d_ready` pulses and `d_rdata` is unchanged. The following load returns `0xDEADBEEF` on `d_rdata`.
- **Simultaneous requests after reset**, both held: grant order is data, fetch, data, fetch. Each ready arrives 5 cycles apart; no cycle has both readies high.
- **Sweep `MEM_LAT` = 1, 3, 7**: ready always appears exactly `MEM_LAT`+2 cycles after the sampled request; exactly one `mem_en` per transaction.
- **Reset asserted during WAIT**: no ready pulse; all outputs 0 the next cycle. A request held through reset is granted in the first IDLE cycle after `reset` returns to 1.
- **Request arriving during RESP** for the other requester: not granted until the IDLE cycle; `mem_en` follows one cycle later.
